// File: rtl/mixed_precision_packer.sv
// mixed_precision_packer: packs N/M/1-element vectors into N-lane words in full or half precision.
// Optional statistics counters are enabled with `define PACKER_STATS_EN.
`default_nettype none
module mixed_precision_packer #(
  parameter int N                  = 8,
  parameter int M                  = 2,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tracing,
  input  logic                           valid_in,
  input  logic [1:0]                     eof_in,
  input  logic [1:0]                     bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0]  chainId_in,
  input  logic                           flush,
  input  logic [7:0]                     configId,
  input  logic [7:0]                     configData,
  input  logic [N*DATA_WIDTH-1:0]        vector_in,
  output logic [N*DATA_WIDTH-1:0]        vector_out,
  output logic                           valid_out,
  output logic                           half_out,
  output logic [$clog2(2*N):0]           fill_out,
  output logic [15:0]                    stat_words,
  output logic [15:0]                    stat_part
);
  localparam int HW   = DATA_WIDTH / 2;
  localparam int BW   = N * DATA_WIDTH;
  localparam int FW   = $clog2(2*N) + 1;
  localparam int CIDW = $clog2(MAX_CHAINS);
  localparam int BCW  = $clog2(2*MAX_CHAINS) + 1;
  localparam logic [FW-1:0] FULL = FW'(2*N);

  logic [2:0]     r_fw   [MAX_CHAINS];
  logic [7:0]     r_cond [MAX_CHAINS];
  logic [BCW-1:0] r_byte_cnt;
  logic [BW-1:0]  r_buf;
  logic [FW-1:0]  r_cnt;
  logic           r_prec;
  logic           r_pending;
  logic [BW-1:0]  r_vec;
  logic           r_valid;
  logic           r_half;
  logic [FW-1:0]  r_fill;

  logic [2:0]     w_fw;
  logic [7:0]     w_cond;
  logic           w_half;
  logic           w_cond_ok;
  logic           w_accept;
  logic [FW-1:0]  w_len;
  logic [FW-1:0]  w_u;
  logic [FW:0]    w_sum;
  logic [BW-1:0]  w_vflat;
  logic [BW-1:0]  w_shifted;
  logic [BW-1:0]  w_buf_n;
  logic [FW-1:0]  w_cnt_n;
  logic           w_prec_n;
  logic           w_pend_n;
  logic           w_emit;
  logic [BW-1:0]  w_word;
  logic [FW-1:0]  w_wfill;
  logic           w_whalf;

  assign w_fw   = r_fw[chainId_in];
  assign w_cond = r_cond[chainId_in];
  assign w_half = w_fw[2];

  assign w_cond_ok = (w_cond == 8'h00)
                   | (w_cond[0] &  eof_in[0]) | (w_cond[1] & ~eof_in[0])
                   | (w_cond[2] &  bof_in[0]) | (w_cond[3] & ~bof_in[0])
                   | (w_cond[4] &  eof_in[1]) | (w_cond[5] & ~eof_in[1])
                   | (w_cond[6] &  bof_in[1]) | (w_cond[7] & ~bof_in[1]);
  assign w_accept  = valid_in & tracing & (w_fw[1:0] != 2'd3) & w_cond_ok;

  always_comb begin
    case (w_fw[1:0])
      2'd0:    w_len = FW'(N);
      2'd1:    w_len = FW'(M);
      default: w_len = FW'(1);
    endcase
  end
  assign w_u = w_half ? w_len : (w_len << 1);

  // Incoming vector laid out from slot 0, slots beyond U kept zero so OR-append is safe.
  always_comb begin
    w_vflat = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(w_len)) begin
        if (w_half) w_vflat[k*HW +: HW] = vector_in[k*DATA_WIDTH +: HW];
        else        w_vflat[k*DATA_WIDTH +: DATA_WIDTH] = vector_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  assign w_shifted = w_vflat << (r_cnt * HW);
  assign w_sum     = {1'b0, r_cnt} + {1'b0, w_u};

  always_comb begin
    w_buf_n  = r_buf;
    w_cnt_n  = r_cnt;
    w_prec_n = r_prec;
    w_pend_n = r_pending;
    w_emit   = 1'b0;
    w_word   = r_buf;
    w_wfill  = r_cnt;
    w_whalf  = r_prec;
    if (w_accept) begin
      w_prec_n = w_half;
      if ((r_cnt != '0) && (w_half != r_prec)) begin
        w_emit  = 1'b1;
        w_buf_n = w_vflat;
        w_cnt_n = w_u;
      end else if (w_sum < {1'b0, FULL}) begin
        w_buf_n = r_buf | w_shifted;
        w_cnt_n = w_sum[FW-1:0];
      end else if (w_sum == {1'b0, FULL}) begin
        w_emit  = 1'b1;
        w_word  = r_buf | w_shifted;
        w_wfill = FULL;
        w_whalf = w_half;
        w_buf_n = '0;
        w_cnt_n = '0;
      end else begin
        w_emit  = 1'b1;
        w_buf_n = w_vflat;
        w_cnt_n = w_u;
      end
    end
    // A flush that collides with an emit is deferred one cycle via the pending flag.
    if (tracing && (flush || r_pending)) begin
      if (w_cnt_n == '0) begin
        w_pend_n = 1'b0;
      end else if (w_emit) begin
        w_pend_n = 1'b1;
      end else begin
        w_emit   = 1'b1;
        w_word   = w_buf_n;
        w_wfill  = w_cnt_n;
        w_whalf  = w_prec_n;
        w_buf_n  = '0;
        w_cnt_n  = '0;
        w_pend_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf     <= '0;
      r_cnt     <= '0;
      r_prec    <= 1'b0;
      r_pending <= 1'b0;
      r_vec     <= '0;
      r_valid   <= 1'b0;
      r_half    <= 1'b0;
      r_fill    <= '0;
    end else begin
      r_buf     <= w_buf_n;
      r_cnt     <= w_cnt_n;
      r_prec    <= w_prec_n;
      r_pending <= w_pend_n;
      r_valid   <= w_emit;
      if (w_emit) begin
        r_vec  <= w_word;
        r_half <= w_whalf;
        r_fill <= w_wfill;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        r_fw[c]   <= '0;
        r_cond[c] <= '0;
      end
    end else if (!tracing) begin
      if (configId == 8'(PERSONAL_CONFIG_ID)) begin
        if (r_byte_cnt < BCW'(MAX_CHAINS)) begin
          r_cond[r_byte_cnt[CIDW-1:0]] <= configData;
        end else if (r_byte_cnt < BCW'(2*MAX_CHAINS)) begin
          r_fw[r_byte_cnt[CIDW-1:0]] <= configData[2:0];
        end
        if (r_byte_cnt < BCW'(2*MAX_CHAINS)) r_byte_cnt <= r_byte_cnt + 1'b1;
      end else begin
        r_byte_cnt <= '0;
      end
    end
  end

`ifdef PACKER_STATS_EN
  logic [15:0] r_stat_words;
  logic [15:0] r_stat_part;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_words <= '0;
      r_stat_part  <= '0;
    end else if (w_emit) begin
      r_stat_words <= r_stat_words + 16'd1;
      if (w_wfill < FULL) r_stat_part <= r_stat_part + 16'd1;
    end
  end
  assign stat_words = r_stat_words;
  assign stat_part  = r_stat_part;
`else
  assign stat_words = 16'd0;
  assign stat_part  = 16'd0;
`endif

  assign vector_out = r_vec;
  assign valid_out  = r_valid;
  assign half_out   = r_half;
  assign fill_out   = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_mixed_precision_packer.sv
// tb_mixed_precision_packer: directed table, corner sequences and random traffic against a slot-queue model.
`default_nettype none
module tb_mixed_precision_packer;
  localparam int N = 8;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tracing, valid_in, flush;
  logic [1:0]     eof_in, bof_in, chainId_in;
  logic [7:0]     configId, configData;
  logic [N*DW-1:0] vector_in, vector_out;
  logic           valid_out, half_out;
  logic [4:0]     fill_out;
  logic [15:0]    stat_words, stat_part;

  mixed_precision_packer dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in), .flush(flush),
    .configId(configId), .configData(configData), .vector_in(vector_in),
    .vector_out(vector_out), .valid_out(valid_out), .half_out(half_out),
    .fill_out(fill_out), .stat_words(stat_words), .stat_part(stat_part)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [255:0] a, logic [255:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endfunction

  // Reference model: buffer as a queue of half-width slots.
  logic [15:0]  mq[$];
  bit           mprec, mpend;
  logic [7:0]   mfw[4];
  logic [7:0]   mcond[4];
  int           mbc;
  bit           e_valid, e_half;
  logic [255:0] e_word;
  logic [4:0]   e_fill;
  logic [15:0]  e_sw, e_sp;

  function automatic void m_reset();
    mq.delete(); mprec = 0; mpend = 0; mbc = 0;
    for (int i = 0; i < 4; i++) begin mfw[i] = 0; mcond[i] = 0; end
    e_valid = 0; e_half = 0; e_word = '0; e_fill = 0; e_sw = 0; e_sp = 0;
  endfunction

  function automatic void m_emit(bit p);
    e_valid = 1; e_word = '0;
    for (int i = 0; i < mq.size(); i++) e_word[i*16 +: 16] = mq[i];
    e_fill = 5'(mq.size()); e_half = p;
`ifdef PACKER_STATS_EN
    e_sw++;
    if (mq.size() < 16) e_sp++;
`endif
  endfunction

  function automatic void m_step();
    logic [15:0] v[$];
    logic [7:0] fwv, cd;
    bit hf, ok;
    int L;
    e_valid = 0;
    if (!tracing) begin
      if (configId == 8'd0) begin
        if (mbc < 4) mcond[mbc] = configData;
        else if (mbc < 8) mfw[mbc-4] = configData;
        if (mbc < 8) mbc++;
      end else mbc = 0;
      return;
    end
    fwv = mfw[chainId_in]; cd = mcond[chainId_in]; hf = fwv[2];
    ok = (cd == 0) || (cd[0] && eof_in[0]) || (cd[1] && !eof_in[0]) || (cd[2] && bof_in[0]) ||
         (cd[3] && !bof_in[0]) || (cd[4] && eof_in[1]) || (cd[5] && !eof_in[1]) ||
         (cd[6] && bof_in[1]) || (cd[7] && !bof_in[1]);
    if (valid_in && fwv[1:0] != 2'd3 && ok) begin
      L = (fwv[1:0] == 0) ? N : (fwv[1:0] == 1) ? 2 : 1;
      for (int k = 0; k < L; k++) begin
        v.push_back(vector_in[k*DW +: 16]);
        if (!hf) v.push_back(vector_in[k*DW+16 +: 16]);
      end
      if (mq.size() > 0 && hf != mprec) begin
        m_emit(mprec); mq = v;
      end else if (mq.size() + v.size() <= 2*N) begin
        mq = {mq, v};
        if (mq.size() == 2*N) begin m_emit(hf); mq.delete(); end
      end else begin
        m_emit(mprec); mq = v;
      end
      mprec = hf;
    end
    if (flush || mpend) begin
      if (mq.size() == 0) mpend = 0;
      else if (e_valid) mpend = 1;
      else begin m_emit(mprec); mq.delete(); mpend = 0; end
    end
  endfunction

  task automatic tick();
    m_step();
    @(posedge clk); #1;
    chk("valid_out", 256'(valid_out), 256'(e_valid));
    chk("vector_out", vector_out, e_word);
    chk("fill_out", 256'(fill_out), 256'(e_fill));
    chk("half_out", 256'(half_out), 256'(e_half));
    chk("stat_words", 256'(stat_words), 256'(e_sw));
    chk("stat_part", 256'(stat_part), 256'(e_sp));
  endtask

  function automatic logic [63:0] cfgb(logic [7:0] c0, c1, c2, c3, f0, f1, f2, f3);
    return {f3, f2, f1, f0, c3, c2, c1, c0};
  endfunction

  task automatic cfg(input logic [63:0] bytes);
    tracing = 0; valid_in = 0; flush = 0; configId = 8'hFF;
    tick();
    for (int i = 0; i < 8; i++) begin
      configId = 8'h00; configData = bytes[i*8 +: 8];
      tick();
    end
    configId = 8'hFF; tracing = 1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [255:0] v, input bit fl);
    valid_in = 1; chainId_in = ch; vector_in = v; flush = fl;
    tick();
    valid_in = 0; flush = 0;
  endtask

  function automatic logic [255:0] mkvec(logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = base + 32'(k);
    return r;
  endfunction

  function automatic logic [31:0] lane(int i);
    return vector_out[i*DW +: DW];
  endfunction

  typedef struct {
    logic [7:0]  fw;
    logic [31:0] base;
    bit          ev;
    logic [4:0]  efill;
    bit          ehalf;
    logic [31:0] l0, l1;
  } rec_t;

  task automatic mseq(input bit flush_on_ovf);
    cfg(cfgb(0, 0, 0, 0, 8'h01, 0, 0, 0));
    for (int v = 1; v <= 3; v++) send(2'd0, mkvec(32'(v) * 32'h100), 0);
    cfg(cfgb(0, 0, 0, 0, 8'h00, 0, 0, 0));
    send(2'd0, mkvec(32'h900), flush_on_ovf);
    chk("ovf_valid", 256'(valid_out), 256'(1'b1));
    chk("ovf_fill", 256'(fill_out), 256'(5'd12));
    chk("ovf_lane0", 256'(lane(0)), 256'(32'h100));
    chk("ovf_lane5", 256'(lane(5)), 256'(32'h301));
    chk("ovf_lane67", 256'({lane(7), lane(6)}), 256'(0));
    if (!flush_on_ovf) flush = 1;
    tick();
    flush = 0;
    chk("held_valid", 256'(valid_out), 256'(1'b1));
    chk("held_fill", 256'(fill_out), 256'(5'd16));
    chk("held_lane7", 256'(lane(7)), 256'(32'h907));
    tick();
    chk("held_once", 256'(valid_out), 256'(1'b0));
  endtask

  rec_t tbl[8];

  initial begin
    tbl[0] = '{8'h00, 32'h11110000, 1, 5'd16, 0, 32'h11110000, 32'h11110001};
    tbl[1] = '{8'h01, 32'hA0A00010, 1, 5'd4,  0, 32'hA0A00010, 32'hA0A00011};
    tbl[2] = '{8'h02, 32'h12345678, 1, 5'd2,  0, 32'h12345678, 32'h00000000};
    tbl[3] = '{8'h04, 32'hDEAD0100, 1, 5'd8,  1, 32'h01010100, 32'h01030102};
    tbl[4] = '{8'h05, 32'hBEEF00F0, 1, 5'd2,  1, 32'h00F100F0, 32'h00000000};
    tbl[5] = '{8'h06, 32'hCAFE7777, 1, 5'd1,  1, 32'h00007777, 32'h00000000};
    tbl[6] = '{8'h03, 32'h55555555, 0, 5'd0,  0, 32'h0, 32'h0};
    tbl[7] = '{8'h0E, 32'h0000ABCD, 1, 5'd1,  1, 32'h0000ABCD, 32'h00000000};

    rst_n = 0; tracing = 1; valid_in = 0; flush = 0; eof_in = 0; bof_in = 0;
    chainId_in = 0; configId = 8'hFF; configData = 0; vector_in = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 256'(valid_out), 256'(0));
    chk("rst_vector", vector_out, 256'(0));
    chk("rst_fill", 256'(fill_out), 256'(0));
    chk("rst_half", 256'(half_out), 256'(0));
    rst_n = 1;

    // Reset firmware is length N full precision: immediate word.
    send(2'd0, mkvec(32'h1), 0);
    chk("fw0_default_valid", 256'(valid_out), 256'(1'b1));
    chk("fw0_default_lane7", 256'(lane(7)), 256'(32'h8));

    for (int r = 0; r < 8; r++) begin
      cfg(cfgb(0, 0, 0, 0, tbl[r].fw, 0, 0, 0));
      send(2'd0, mkvec(tbl[r].base), 1);
      chk($sformatf("tbl%0d_valid", r), 256'(valid_out), 256'(tbl[r].ev));
      if (tbl[r].ev) begin
        chk($sformatf("tbl%0d_fill", r), 256'(fill_out), 256'(tbl[r].efill));
        chk($sformatf("tbl%0d_half", r), 256'(half_out), 256'(tbl[r].ehalf));
        chk($sformatf("tbl%0d_lane0", r), 256'(lane(0)), 256'(tbl[r].l0));
        chk($sformatf("tbl%0d_lane1", r), 256'(lane(1)), 256'(tbl[r].l1));
      end
      tick();
    end

    // Sixteen half singletons make exactly one word.
    cfg(cfgb(0, 0, 0, 0, 8'h06, 0, 0, 0));
    begin
      int words = 0;
      for (int i = 1; i <= 16; i++) begin
        logic [255:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = $urandom;
        v[31:0] = {16'($urandom), 16'(i)};
        send(2'd0, v, 0);
        if (valid_out) words++;
      end
      chk("half16_words", 256'(words), 256'(1));
      chk("half16_lane0", 256'(lane(0)), 256'(32'h00020001));
      chk("half16_lane7", 256'(lane(7)), 256'(32'h0010000F));
      chk("half16_fill", 256'(fill_out), 256'(5'd16));
    end

    mseq(0);
    mseq(1);

    // Precision mismatch between chains.
    cfg(cfgb(0, 0, 0, 0, 8'h01, 8'h05, 0, 0));
    send(2'd0, mkvec(32'h50), 0);
    send(2'd1, mkvec(32'hAB0060), 0);
    chk("mis_valid", 256'(valid_out), 256'(1'b1));
    chk("mis_fill", 256'(fill_out), 256'(5'd4));
    chk("mis_half", 256'(half_out), 256'(1'b0));
    chk("mis_lane1", 256'(lane(1)), 256'(32'h51));
    flush = 1; tick(); flush = 0;
    chk("mis_flush_fill", 256'(fill_out), 256'(5'd2));
    chk("mis_flush_lane0", 256'(lane(0)), 256'(32'h00610060));

    // Three half singletons then flush.
    cfg(cfgb(0, 0, 0, 0, 8'h06, 0, 0, 0));
    send(2'd0, mkvec(32'h7777AAA1), 0);
    send(2'd0, mkvec(32'h1234AAA2), 0);
    send(2'd0, mkvec(32'hFFFFAAA3), 0);
    flush = 1; tick(); flush = 0;
    chk("fl3_fill", 256'(fill_out), 256'(5'd3));
    chk("fl3_lane0", 256'(lane(0)), 256'(32'hAAA2AAA1));
    chk("fl3_lane1", 256'(lane(1)), 256'(32'h0000AAA3));

    // Condition on eof level 0.
    cfg(cfgb(8'h01, 0, 0, 0, 8'h00, 0, 0, 0));
    eof_in = 2'b10;
    send(2'd0, mkvec(32'h40), 0);
    chk("cond_drop", 256'(valid_out), 256'(1'b0));
    eof_in = 2'b01;
    send(2'd0, mkvec(32'h40), 0);
    chk("cond_accept", 256'(valid_out), 256'(1'b1));
    eof_in = 2'b00;

    // Asynchronous reset while a word is on the output.
    cfg(cfgb(0, 0, 0, 0, 8'h00, 0, 0, 0));
    send(2'd0, mkvec(32'h77), 0);
    rst_n = 0; #1;
    chk("arst_valid", 256'(valid_out), 256'(0));
    chk("arst_fill", 256'(fill_out), 256'(0));
    m_reset();
    @(posedge clk); #1; rst_n = 1;

    for (int ep = 0; ep < 10; ep++) begin
      logic [63:0] b;
      for (int i = 0; i < 4; i++) b[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      for (int i = 4; i < 8; i++) b[i*8 +: 8] = 8'($urandom);
      cfg(b);
      for (int c = 0; c < 200; c++) begin
        tracing = ($urandom_range(0, 15) != 0);
        configId = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        configData = 8'($urandom);
        valid_in = ($urandom_range(0, 3) != 0);
        chainId_in = 2'($urandom);
        eof_in = 2'($urandom); bof_in = 2'($urandom);
        flush = ($urandom_range(0, 7) == 0);
        for (int k = 0; k < N; k++) vector_in[k*DW +: DW] = $urandom;
        tick();
      end
      valid_in = 0; flush = 0; tracing = 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
